// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART program loader.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, start/data/stop FSM and baud counter.
// Emits a one-cycle byte_valid on a good stop bit, frame_err_pulse on a bad one.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstB,
    input  logic       en,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_pulse
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic              rx_meta;
    logic              rxs;
    uart_rx_state_e    state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic              err_wait;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            state           <= IDLE;
            baud_cnt        <= '0;
            bit_idx         <= '0;
            err_wait        <= 1'b0;
            byte_data       <= '0;
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
        end else begin
            byte_valid      <= 1'b0;
            frame_err_pulse <= 1'b0;
            if (!en) begin
                state    <= IDLE;
                baud_cnt <= '0;
                err_wait <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            baud_cnt <= '0;
                        end
                    end
                    START: begin
                        // Mid-start-bit recheck rejects glitches shorter than half a bit.
                        if (baud_cnt == HALF_LAST) begin
                            baud_cnt <= '0;
                            bit_idx  <= '0;
                            state    <= rxs ? IDLE : DATA;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    DATA: begin
                        if (baud_cnt == FULL_LAST) begin
                            baud_cnt  <= '0;
                            byte_data <= {rxs, byte_data[7:1]};
                            bit_idx   <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) state <= STOP;
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    STOP: begin
                        if (err_wait) begin
                            if (rxs) begin
                                err_wait <= 1'b0;
                                state    <= IDLE;
                            end
                        end else if (baud_cnt == FULL_LAST) begin
                            baud_cnt <= '0;
                            if (rxs) begin
                                byte_valid <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                frame_err_pulse <= 1'b1;
                                err_wait        <= 1'b1;
                            end
                        end else begin
                            baud_cnt <= baud_cnt + BAUD_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: packs UART bytes little-endian into 32-bit instruction-RAM writes
// and holds the core in reset while loading. Define UART_PROG_LOADER_CHECKSUM_EN for csum.
module uart_prog_loader
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int PROG_BYTES   = 256,
    parameter int ADDR_W       = $clog2(PROG_BYTES / 4),
    parameter int CNT_W        = $clog2(PROG_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              progEn,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [CNT_W-1:0]  byte_cnt,
    output logic              done,
    output logic              frame_err,
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    output logic [7:0]        csum,
`endif
    output logic              cpu_rstB
);

    logic              prog_en_q;
    logic              release_pend;
    logic [31:0]       word_buf;
    logic [31:0]       merged;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err_pulse;
    logic              prog_rise;
    logic              prog_fall;
    logic              accept;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] word_addr;

    assign prog_rise = progEn & ~prog_en_q;
    assign prog_fall = ~progEn & prog_en_q;
    assign accept    = byte_valid & progEn & ~done;
    assign lane      = byte_cnt[1:0];
    assign word_addr = byte_cnt[ADDR_W+1:2];

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk            (clk),
        .rstB           (rstB),
        .en             (progEn & ~done),
        .rx             (rx),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .frame_err_pulse(frame_err_pulse)
    );

    // NOTE: assign a default before the partial overwrite so always_comb never infers a latch.
    always_comb begin
        merged = word_buf;
        merged[{lane, 3'b000} +: 8] = byte_data;
    end

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            prog_en_q    <= 1'b0;
            release_pend <= 1'b0;
            word_buf     <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            byte_cnt     <= '0;
            done         <= 1'b0;
            frame_err    <= 1'b0;
            cpu_rstB     <= 1'b0;
        end else begin
            prog_en_q    <= progEn;
            mem_we       <= 1'b0;
            release_pend <= 1'b0;
            if (prog_rise) begin
                byte_cnt  <= '0;
                done      <= 1'b0;
                frame_err <= 1'b0;
                word_buf  <= '0;
                cpu_rstB  <= 1'b0;
            end else if (prog_fall) begin
                // A partial word is flushed first; the core leaves reset the cycle after.
                if (lane != 2'd0) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= word_addr;
                    mem_wdata    <= word_buf;
                    word_buf     <= '0;
                    release_pend <= 1'b1;
                end else begin
                    cpu_rstB <= 1'b1;
                end
            end else begin
                if (release_pend) cpu_rstB <= 1'b1;
                if (frame_err_pulse) frame_err <= 1'b1;
                if (accept) begin
                    byte_cnt <= byte_cnt + CNT_W'(1);
                    done     <= (byte_cnt == CNT_W'(PROG_BYTES - 1));
                    if (lane == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= word_addr;
                        mem_wdata <= merged;
                        word_buf  <= '0;
                    end else begin
                        word_buf <= merged;
                    end
                end
            end
        end
    end

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            csum <= '0;
        end else if (prog_rise) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum + byte_data;
        end
    end
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed loads with random gaps and payloads,
// checked against a byte-queue model of the load and its expected word writes.
module tb_uart_prog_loader;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 100_000;
    localparam int CPB        = CLK_FREQ / BAUD;
    localparam int PROG_BYTES = 256;
    localparam int ADDR_W     = 6;
    localparam int CNT_W      = 9;

    logic              clk;
    logic              rstB;
    logic              progEn;
    logic              rx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [CNT_W-1:0]  byte_cnt;
    logic              done;
    logic              frame_err;
    logic              cpu_rstB;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    uart_prog_loader #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .PROG_BYTES(PROG_BYTES)
    ) dut (
        .clk      (clk),
        .rstB     (rstB),
        .progEn   (progEn),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .byte_cnt (byte_cnt),
        .done     (done),
        .frame_err(frame_err),
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        .csum     (csum),
`endif
        .cpu_rstB (cpu_rstB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  m_load[$];
    logic [7:0]  m_csum;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    always @(negedge clk) begin
        if (rstB && mem_we) begin
            got_addr.push_back(32'(mem_addr));
            got_data.push_back(mem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic model_rise();
        m_load.delete();
        m_csum = 8'h00;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int n;
        if (m_load.size() < PROG_BYTES) begin
            m_load.push_back(b);
            m_csum = m_csum + b;
            n = m_load.size();
            if (n % 4 == 0) begin
                exp_addr.push_back(32'(n / 4 - 1));
                exp_data.push_back({m_load[n-1], m_load[n-2], m_load[n-3], m_load[n-4]});
            end
        end
    endtask

    task automatic model_fall();
        int n;
        logic [31:0] w;
        n = m_load.size();
        if (n % 4 != 0) begin
            w = 32'h0;
            for (int k = 0; k < n % 4; k++) w[8*k +: 8] = m_load[n - n % 4 + k];
            exp_addr.push_back(32'(n / 4));
            exp_data.push_back(w);
        end
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
        if (got_addr.size() == exp_addr.size()) begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                check($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
                check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
            end
        end
        got_addr.delete();
        got_data.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 + $urandom_range(0, 4)) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_byte(b, 1'b1);
        model_accept(b);
    endtask

    task automatic start_load(input string tag);
        progEn = 1'b1;
        model_rise();
        @(negedge clk);
        check({tag, "_cpu_rst"}, 32'(cpu_rstB), 32'd0);
        check({tag, "_cnt0"}, 32'(byte_cnt), 32'd0);
        check({tag, "_done0"}, 32'(done), 32'd0);
        check({tag, "_ferr0"}, 32'(frame_err), 32'd0);
    endtask

    task automatic end_load(input string tag);
        logic flush;
        flush = (m_load.size() % 4) != 0;
        progEn = 1'b0;
        model_fall();
        @(negedge clk);
        if (flush) begin
            check({tag, "_flush_we"}, 32'(mem_we), 32'd1);
            check({tag, "_flush_hold"}, 32'(cpu_rstB), 32'd0);
            @(negedge clk);
        end else begin
            check({tag, "_noflush_we"}, 32'(mem_we), 32'd0);
        end
        check({tag, "_release"}, 32'(cpu_rstB), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    logic [7:0] t1_bytes[8];
    logic [7:0] rb;
    int         n_rand;

    initial begin
        t1_bytes = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        rstB   = 1'b0;
        progEn = 1'b0;
        rx     = 1'b1;
        m_csum = 8'h00;
        repeat (3) @(negedge clk);

        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_cnt", 32'(byte_cnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_cpu", 32'(cpu_rstB), 32'd0);
        rstB = 1'b1;
        repeat (3) @(negedge clk);

        // Two complete words
        start_load("t1");
        for (int i = 0; i < 8; i++) send_good(t1_bytes[i]);
        check("t1_cnt", 32'(byte_cnt), 32'd8);
        check_writes("t1");
        end_load("t1");
        check_writes("t1_end");

        // Full program then an overflow byte
        start_load("t2");
        for (int i = 0; i < PROG_BYTES; i++) send_good(8'(i));
        check("t2_done", 32'(done), 32'd1);
        check("t2_cnt", 32'(byte_cnt), 32'd256);
        check("t2_last_addr", got_addr[$], 32'd63);
        check("t2_last_data", got_data[$], 32'hFFFEFDFC);
        check_writes("t2");
        send_good(8'h5A);
        check("t2_sat_cnt", 32'(byte_cnt), 32'd256);
        check("t2_sat_done", 32'(done), 32'd1);
        check_writes("t2_sat");
        end_load("t2");
        check_writes("t2_end");

        // Partial-word flush
        start_load("t3");
        for (int i = 0; i < 6; i++) send_good(8'h11 + 8'(i));
        check_writes("t3_body");
        end_load("t3");
        check("t3_flush_addr", got_addr[$], 32'd1);
        check("t3_flush_data", got_data[$], 32'h00001615);
        check_writes("t3_flush");

        // Random payload lengths and values
        for (int r = 0; r < 4; r++) begin
            start_load("rnd");
            n_rand = $urandom_range(1, 11);
            for (int i = 0; i < n_rand; i++) begin
                rb = 8'($urandom);
                send_good(rb);
            end
            check("rnd_cnt", 32'(byte_cnt), 32'(n_rand));
`ifdef UART_PROG_LOADER_CHECKSUM_EN
            check("rnd_csum", 32'(csum), 32'(m_csum));
`endif
            end_load("rnd");
            check_writes("rnd");
        end

        // Bad stop bit, then a good byte lands in lane 0
        start_load("fe");
        send_byte(8'h55, 1'b0);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_cnt", 32'(byte_cnt), 32'd0);
        send_good(8'hAA);
        check("fe_cnt_after", 32'(byte_cnt), 32'd1);
        end_load("fe");
        check("fe_sticky", 32'(frame_err), 32'd1);
        check("fe_lane0", got_data[$], 32'h000000AA);
        check_writes("fe");

        // Short rx glitch is a false start
        start_load("gl");
        rx = 1'b0;
        repeat (CPB / 3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("gl_cnt", 32'(byte_cnt), 32'd0);
        check("gl_ferr", 32'(frame_err), 32'd0);
        send_good(8'h3C);
        check("gl_cnt_after", 32'(byte_cnt), 32'd1);
        end_load("gl");
        check_writes("gl");

        // Checksum wrap and two-byte flush
        start_load("cs");
        send_good(8'hFF);
        send_good(8'h02);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        check("cs_wrap", 32'(csum), 32'h01);
`endif
        end_load("cs");
        check("cs_flush", got_data[$], 32'h000002FF);
        check_writes("cs");

        // Asynchronous reset in the middle of a byte
        start_load("ar");
        for (int i = 0; i < 5; i++) send_good(8'($urandom_range(1, 255)));
        check("ar_cnt", 32'(byte_cnt), 32'd5);
        check_writes("ar");
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        #2 rstB = 1'b0;
        #1;
        check("ar_we", 32'(mem_we), 32'd0);
        check("ar_addr", 32'(mem_addr), 32'd0);
        check("ar_wdata", mem_wdata, 32'd0);
        check("ar_cnt0", 32'(byte_cnt), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_ferr", 32'(frame_err), 32'd0);
        check("ar_cpu", 32'(cpu_rstB), 32'd0);
        repeat (3) @(negedge clk);
        rstB = 1'b1;
        model_rise();
        repeat (2) @(negedge clk);
        check("ar_cpu_held", 32'(cpu_rstB), 32'd0);
        send_good(8'h77);
        check("ar_cnt_after", 32'(byte_cnt), 32'd1);
        end_load("ar");
        check_writes("ar_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
